node_injector: RTL and testbench

//  Terminal-side injection port: takes packet requests and payload words from a

---
 rtl/node_injector.sv | 146 ++++++++++++++
 tb/tb_node_injector.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/node_injector.sv
// Terminal-side injection port: turns packet requests and payload words
// into head/body/tail flits and tracks per-VC downstream credits.
module node_injector #(
    parameter int num_vcs            = 4,
    parameter int buffer_size        = 8,
    parameter int max_payload_length = 4,
    parameter int flit_data_width    = 64,
    localparam int vc_idx_width    = $clog2(num_vcs),
    localparam int len_width       = $clog2(max_payload_length + 1),
    localparam int credit_width    = $clog2(buffer_size + 1),
    localparam int channel_width   = 1 + vc_idx_width + 2 + flit_data_width,
    localparam int flow_ctrl_width = 1 + vc_idx_width
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       pkt_valid,
    output logic                       pkt_ready,
    input  logic [vc_idx_width-1:0]    pkt_vc,
    input  logic [len_width-1:0]       pkt_len,
    input  logic [flit_data_width-1:0] pkt_head_data,
    input  logic                       pld_valid,
    output logic                       pld_ready,
    input  logic [flit_data_width-1:0] pld_data,
    output logic [channel_width-1:0]   channel_out,
    input  logic [flow_ctrl_width-1:0] flow_ctrl_in,
    output logic                       busy,
    output logic                       error
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HEAD = 2'd1;
    localparam logic [1:0] BODY = 2'd2;

    logic [1:0]                 state;
    logic [vc_idx_width-1:0]    vc_q;
    logic [len_width-1:0]       len_q;
    logic [len_width-1:0]       remaining;
    logic [flit_data_width-1:0] head_q;
    logic [credit_width-1:0]    credit [num_vcs];

    logic                       credit_valid;
    logic [vc_idx_width-1:0]    credit_vc;
    logic                       has_credit;
    logic                       head_send;
    logic                       body_send;
    logic                       send;
    logic                       accept;
    logic                       oversize;
    logic                       flit_tail;
    logic [flit_data_width-1:0] flit_data;
    logic [num_vcs-1:0]         inc;
    logic [num_vcs-1:0]         dec;
    logic                       overflow;

    assign credit_valid = flow_ctrl_in[flow_ctrl_width-1];
    assign credit_vc    = flow_ctrl_in[vc_idx_width-1:0];

    assign pkt_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = pkt_ready && pkt_valid;
    assign oversize  = pkt_len > len_width'(max_payload_length);

    assign has_credit = (credit[vc_q] != '0);
    assign head_send  = (state == HEAD) && has_credit;
    assign body_send  = (state == BODY) && has_credit && pld_valid;
    assign send       = head_send || body_send;
    assign pld_ready  = body_send;

    assign flit_tail = head_send ? (len_q == '0)
                                 : (remaining == len_width'(1));
    assign flit_data = head_send ? head_q : pld_data;

    // A send and a return on the same VC cancel out
    always_comb begin
        inc      = '0;
        dec      = '0;
        overflow = 1'b0;
        for (int v = 0; v < num_vcs; v++) begin
            inc[v] = credit_valid && (credit_vc == vc_idx_width'(v));
            dec[v] = send && (vc_q == vc_idx_width'(v));
            if (inc[v] && !dec[v] &&
                credit[v] == credit_width'(buffer_size))
                overflow = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < num_vcs; v++)
                credit[v] <= credit_width'(buffer_size);
        end else begin
            for (int v = 0; v < num_vcs; v++) begin
                if (inc[v] && !dec[v]) begin
                    if (credit[v] != credit_width'(buffer_size))
                        credit[v] <= credit[v] + 1'b1;
                end else if (dec[v] && !inc[v]) begin
                    credit[v] <= credit[v] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            vc_q        <= '0;
            len_q       <= '0;
            remaining   <= '0;
            head_q      <= '0;
            channel_out <= '0;
            error       <= 1'b0;
        end else begin
            error <= error || overflow || (accept && oversize);
            if (send)
                channel_out <= {1'b1, vc_q, head_send, flit_tail, flit_data};
            else
                channel_out <= '0;
            unique case (state)
                IDLE: begin
                    if (pkt_valid) begin
                        vc_q   <= pkt_vc;
                        head_q <= pkt_head_data;
                        len_q  <= oversize ? len_width'(max_payload_length)
                                           : pkt_len;
                        state  <= HEAD;
                    end
                end
                HEAD: begin
                    if (head_send) begin
                        remaining <= len_q;
                        state     <= (len_q == '0) ? IDLE : BODY;
                    end
                end
                BODY: begin
                    if (body_send) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == len_width'(1))
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_node_injector.sv
// Directed bench for node_injector: scoreboarded flits, latency,
// credit accounting, overflow/oversize error and mid-packet reset.
module tb_node_injector;

    localparam int CW = 69;
    localparam logic [63:0] BASE = 64'hB000_0000_0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [1:0]  pkt_vc;
    logic [2:0]  pkt_len;
    logic [63:0] pkt_head_data;
    logic        pld_valid;
    logic        pld_ready;
    logic [63:0] pld_data;
    logic [CW-1:0] channel_out;
    logic [2:0]  flow_ctrl_in;
    logic        busy;
    logic        error;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int flits_seen = 0;
    int last_flit_cyc = -1;
    int busy_cnt = 0;
    int pld_idx = 0;
    int exp_pld_idx = 0;
    logic [CW-1:0] sb [$];

    assign pld_data = BASE + 64'(pld_idx);

    always #5 clk = ~clk;

    node_injector dut (
        .clk           (clk),
        .reset         (reset),
        .pkt_valid     (pkt_valid),
        .pkt_ready     (pkt_ready),
        .pkt_vc        (pkt_vc),
        .pkt_len       (pkt_len),
        .pkt_head_data (pkt_head_data),
        .pld_valid     (pld_valid),
        .pld_ready     (pld_ready),
        .pld_data      (pld_data),
        .channel_out   (channel_out),
        .flow_ctrl_in  (flow_ctrl_in),
        .busy          (busy),
        .error         (error)
    );

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit r;
        r = pld_ready;
        busy_cnt += int'(busy);
        @(posedge clk);
        #1;
        cyc++;
        if (r) pld_idx++;
        if (channel_out[CW-1]) begin
            flits_seen++;
            last_flit_cyc = cyc;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_flit: observed %0h expected none",
                       channel_out);
            end else begin
                chk("flit", channel_out, sb.pop_front());
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic credit(input logic [1:0] vc);
        flow_ctrl_in = {1'b1, vc};
        step();
        flow_ctrl_in = '0;
    endtask

    task automatic send_pkt(input logic [1:0] vc, input int len,
                            input logic [63:0] hd, output int acc);
        int n = 0;
        int nb;
        while (!pkt_ready && n < 60) begin
            step();
            n++;
        end
        if (!pkt_ready) begin
            tests++;
            fails++;
            $error("FAIL pkt_ready_timeout: observed 0 expected 1");
        end
        pkt_valid     = 1'b1;
        pkt_vc        = vc;
        pkt_len       = 3'(len);
        pkt_head_data = hd;
        nb = (len > 4) ? 4 : len;
        sb.push_back({1'b1, vc, 1'b1, (nb == 0), hd});
        for (int i = 0; i < nb; i++) begin
            sb.push_back({1'b1, vc, 1'b0, (i == nb - 1),
                          BASE + 64'(exp_pld_idx)});
            exp_pld_idx++;
        end
        acc = cyc;
        step();
        pkt_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        sb.delete();
        exp_pld_idx = pld_idx;
        chk("rst_channel", channel_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pkt_ready", pkt_ready, 1);
        chk("rst_pld_ready", pld_ready, 0);
        chk("rst_error", error, 0);
        for (int v = 0; v < 4; v++)
            chk("rst_credit", dut.credit[v], 8);
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int f0;
        int n;
        reset         = 1'b0;
        pkt_valid     = 1'b0;
        pkt_vc        = '0;
        pkt_len       = '0;
        pkt_head_data = '0;
        pld_valid     = 1'b0;
        flow_ctrl_in  = '0;
        @(posedge clk);
        #1;
        do_reset();
        idle(2);

        // head-only packet: two-cycle request-to-wire latency
        pld_valid = 1'b1;
        chk("pld_ready_idle", pld_ready, 0);
        send_pkt(2'd1, 0, 64'hA5, c0);
        chk("t1_busy", busy, 1);
        chk("t1_no_flit_yet", channel_out[CW-1], 0);
        step();
        chk("t1_latency", last_flit_cyc, c0 + 2);
        chk("t1_credit1", dut.credit[1], 7);
        idle(2);
        chk("t1_idle", busy, 0);

        // len=3 with payload always valid: 4 back-to-back flits
        f0 = flits_seen;
        busy_cnt = 0;
        send_pkt(2'd2, 3, 64'h2222, c0);
        idle(8);
        chk("t2_flits", flits_seen - f0, 4);
        chk("t2_last", last_flit_cyc, c0 + 5);
        chk("t2_busy_cycles", busy_cnt, 4);

        // exhaust vc0: 8 flits go, the 9th waits for a credit
        f0 = flits_seen;
        send_pkt(2'd0, 2, 64'h3001, c0);
        send_pkt(2'd0, 2, 64'h3002, c0);
        send_pkt(2'd0, 2, 64'h3003, c0);
        idle(6);
        chk("t3_flits", flits_seen - f0, 8);
        chk("t3_stalled_busy", busy, 1);
        chk("t3_credit0", dut.credit[0], 0);
        chk("t3_pending", sb.size(), 1);
        n = cyc;
        credit(2'd0);
        chk("t3_no_bypass", channel_out[CW-1], 0);
        step();
        chk("t3_ninth_cyc", last_flit_cyc, n + 2);
        chk("t3_ninth", flits_seen - f0, 9);
        chk("t3_drained", sb.size(), 0);
        idle(2);

        // simultaneous send and return
        credit(2'd0);
        credit(2'd0);
        chk("t4_credit0_pre", dut.credit[0], 2);
        send_pkt(2'd0, 0, 64'h4400, c0);
        flow_ctrl_in = {1'b1, 2'd0};
        step();
        flow_ctrl_in = '0;
        chk("t4_same_vc", dut.credit[0], 2);
        send_pkt(2'd0, 0, 64'h4500, c0);
        flow_ctrl_in = {1'b1, 2'd1};
        step();
        flow_ctrl_in = '0;
        chk("t4_diff_vc0", dut.credit[0], 1);
        chk("t4_diff_vc1", dut.credit[1], 8);
        chk("t4_no_error", error, 0);
        idle(2);

        // credit overflow saturates and sets sticky error
        @(posedge clk);
        #1;
        do_reset();
        credit(2'd2);
        chk("t5_saturate", dut.credit[2], 8);
        chk("t5_error", error, 1);
        idle(3);
        chk("t5_sticky", error, 1);

        // oversize length clamps; reset mid-body abandons packet
        do_reset();
        idle(1);
        chk("t6_error_clear", error, 0);
        f0 = flits_seen;
        send_pkt(2'd3, 7, 64'h6600, c0);
        chk("t6_error", error, 1);
        idle(10);
        chk("t6_flits", flits_seen - f0, 5);
        chk("t6_drained", sb.size(), 0);
        f0 = flits_seen;
        send_pkt(2'd3, 4, 64'h7700, c0);
        step();
        step();
        chk("t6_mid_busy", busy, 1);
        do_reset();
        idle(3);
        chk("t6_abandoned", flits_seen - f0, 2);
        chk("t6_post_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
